microwave_timer_ctrl: RTL and testbench
=======================================

# microwave_timer_ctrl

Sequencing controller for the microwave cook timer. Collects BCD keypad digits into a 4-digit MM:SS entry register, loads it into the cascaded mod-10/mod-6 down-counter chain, and gates the chain's count enable with the 1 Hz tick. It handles start, pause, resume and cancel, and the door interlock. On reaching 00:00 it drives the magnetron off and an alarm. It sits between the keypad/door sensors and the counter chain.

## Interface
- ALARM_TICKS, 3: ticks the alarm stays high in DONE (1..15).
- clock  in  1  system clock, all state on rising edge.
- clear  in  1  synchronous active-high reset.
- tick  in  1  one-cycle 1 Hz strobe.
- key_valid  in  1  one-cycle keypad strobe.
- key_value  in  4  BCD digit qualified by key_valid.
- start  in  1  start/resume pulse.
- stop  in  1  pause/cancel pulse.
- door_closed  in  1  1 = door latched.
- zero_all  in  1  counter chain reads 00:00.
- data  out  16  {min_tens, min_ones, sec_tens, sec_ones} to counter load inputs.
- loadn  out  1  active-low load to counter chain.
- count_en  out  1  enable to the least-significant counter.
- magnetron_on  out  1  heating active.
- alarm  out  1  cook-complete alarm.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, LOAD, COOKING, PAUSED, DONE.
- Entry register (16 b) shifts left 4 b on key_valid, with the new digit placed in sec_ones.
  - Accepted in IDLE only.
  - key_value > 9 is ignored.
  - A 5th digit drops min_tens.
  - No range check: 99:99 loads as-is.
- data = entry register in all states except the cancel load, where data = 0.
- IDLE → LOAD: start & door_closed & entry ≠ 0.
- LOAD (exactly 1 cycle): loadn = 0. Then → COOKING and the entry register clears.
- COOKING:
  - count_en = tick & ~zero_all (combinational).
  - magnetron_on = 1.
  - tick & zero_all → DONE. The chain never wraps.
  - ~door_closed or stop → PAUSED.
- PAUSED:
  - start & door_closed → COOKING (resume, no reload).
  - stop → IDLE with a one-cycle cancel load (loadn = 0, data = 0) on the transition cycle.
- DONE:
  - alarm = 1.
  - Exits to IDLE after ALARM_TICKS ticks, or earlier on stop, key_valid or ~door_closed.
- Priority within a cycle: clear > ~door_closed > stop > start > key_valid.
- start and stop together → stop.
- start with door open is ignored in every state.
- Reset values:
  - state IDLE, entry 0.
  - loadn 1, count_en 0, magnetron_on 0, alarm 0, busy 0.
  - data 0.
- Reset mid-cook returns to IDLE immediately. The counter chain is not reloaded; its own clear handles that.

## Timing
- Inputs are sampled at rising edge N. The state changes at N+1.
- loadn is registered: low for cycle N+1 after start is sampled at edge N. magnetron_on rises at N+2.
- count_en is combinational from the state, tick and zero_all. The chain decrements on the same edge that samples tick.
- magnetron_on and alarm are registered, decoded from the state register.
- DONE is entered on the edge after the tick that finds zero_all = 1. magnetron_on falls on that same edge.
- Alarm tick counter: 4 bits, cleared on DONE entry, incremented per tick. It exits when count = ALARM_TICKS - 1 and a tick occurs.

## Configuration
- QUICK_START_EN defined:
  - start in IDLE with entry = 0 and door closed loads 00:30 (data = 16'h0030) via LOAD.
  - Each start during COOKING adds 30 s by loading (current time + 30 s)? No: it reloads 00:30 only if zero_all; otherwise it is ignored.
- QUICK_START_EN undefined: start with entry = 0 is ignored; IDLE is held.

## Test plan
- Keys 1, 2, 3, 0 then start, door closed → data = 16'h1230, loadn low for exactly one cycle, magnetron_on = 1 next cycle, count_en pulses once per tick.
- Entry 00:02 cooking, zero_all rises after 2 ticks → next tick gives count_en = 0, DONE, alarm = 1 for 3 ticks, then IDLE with busy = 0.
- Door opened mid-cook → PAUSED, magnetron_on = 0, count_en = 0 despite ticks; door closed and start → COOKING with no loadn pulse.
- stop in PAUSED → IDLE with loadn = 0 and data = 0 for one cycle; start and stop in the same cycle while COOKING → PAUSED.
- start with entry 0 → stays IDLE; with QUICK_START_EN defined → data = 16'h0030, loadn pulse, COOKING.
- clear asserted during COOKING → next edge all outputs at reset values; key_value = 4'hA is ignored.

Source files
------------

// File: rtl/microwave_timer_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// microwave_timer_ctrl_if
// Keypad/door/counter-chain signal bundle for the cook timer controller.
// slave  : the controller itself.
// master : the keypad, door sensor and counter chain side.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface microwave_timer_ctrl_if;
  logic        tick;
  logic        key_valid;
  logic [3:0]  key_value;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        zero_all;
  logic [15:0] data;
  logic        loadn;
  logic        count_en;
  logic        magnetron_on;
  logic        alarm;
  logic        busy;

  modport slave (
    input  tick, key_valid, key_value, start, stop, door_closed, zero_all,
    output data, loadn, count_en, magnetron_on, alarm, busy
  );

  modport master (
    output tick, key_valid, key_value, start, stop, door_closed, zero_all,
    input  data, loadn, count_en, magnetron_on, alarm, busy
  );
endinterface
`default_nettype wire

// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// microwave_timer_ctrl
// Cook timer sequencer: BCD MM:SS entry, load of the down-counter chain,
// tick-gated count enable, pause/resume/cancel, door interlock and alarm.
// Optional feature macro: QUICK_START_EN (start with empty entry cooks 00:30;
// start while cooking at 00:00 reloads 00:30).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int ALARM_TICKS = 3
) (
  input  logic                  clock,
  input  logic                  clear,
  microwave_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COOKING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] C_ALARM_LAST = 4'(ALARM_TICKS - 1);
`ifdef QUICK_START_EN
  localparam logic [15:0] C_QUICK_TIME = 16'h0030;
`endif

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [3:0]  alarm_cnt_q, alarm_cnt_d;
  logic        cancel_q, cancel_d;
  logic        loadn_q, loadn_d;
  logic        magnetron_q, magnetron_d;
  logic        alarm_q, alarm_d;
  logic        w_key_ok;

  assign w_key_ok = bus.key_valid && (bus.key_value <= 4'd9);

  // Next-state, entry register and alarm counter; the highest-priority event
  // active in a cycle (door open > stop > start > key) decides the action and
  // all lower-priority events in that cycle are dropped.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    alarm_cnt_d = alarm_cnt_q;
    cancel_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.door_closed && !bus.stop) begin
          if (bus.start) begin
            if (entry_q != 16'h0000) begin
              state_d = S_LOAD;
            end
`ifdef QUICK_START_EN
            else begin
              entry_d = C_QUICK_TIME;
              state_d = S_LOAD;
            end
`endif
          end else if (w_key_ok) begin
            entry_d = {entry_q[11:0], bus.key_value};
          end
        end
      end
      S_LOAD: begin
        state_d = S_COOKING;
        entry_d = 16'h0000;
      end
      S_COOKING: begin
        if (!bus.door_closed || bus.stop) begin
          state_d = S_PAUSED;
        end
`ifdef QUICK_START_EN
        else if (bus.start && bus.zero_all) begin
          entry_d = C_QUICK_TIME;
          state_d = S_LOAD;
        end
`endif
        else if (bus.tick && bus.zero_all) begin
          state_d     = S_DONE;
          alarm_cnt_d = 4'd0;
        end
      end
      S_PAUSED: begin
        if (bus.door_closed) begin
          if (bus.stop) begin
            state_d  = S_IDLE;
            cancel_d = 1'b1;
          end else if (bus.start) begin
            state_d = S_COOKING;
          end
        end
      end
      S_DONE: begin
        if (!bus.door_closed || bus.stop || bus.key_valid) begin
          state_d = S_IDLE;
        end else if (bus.tick) begin
          if (alarm_cnt_q == C_ALARM_LAST) begin
            state_d = S_IDLE;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state register.
    loadn_d     = !((state_d == S_LOAD) || cancel_d);
    magnetron_d = (state_d == S_COOKING);
    alarm_d     = (state_d == S_DONE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      entry_q     <= 16'h0000;
      alarm_cnt_q <= 4'd0;
      cancel_q    <= 1'b0;
      loadn_q     <= 1'b1;
      magnetron_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      alarm_cnt_q <= alarm_cnt_d;
      cancel_q    <= cancel_d;
      loadn_q     <= loadn_d;
      magnetron_q <= magnetron_d;
      alarm_q     <= alarm_d;
    end
  end

  // The cancel load forces the chain to 00:00; otherwise the chain sees the entry.
  assign bus.data         = cancel_q ? 16'h0000 : entry_q;
  assign bus.loadn        = loadn_q;
  // The chain decrements on the same edge that samples the tick, and must
  // stop at 00:00 rather than wrap.
  assign bus.count_en     = (state_q == S_COOKING) && bus.tick && !bus.zero_all;
  assign bus.magnetron_on = magnetron_q;
  assign bus.alarm        = alarm_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_microwave_timer_ctrl
// Directed scenarios with literal expectations, then randomized stimulus
// checked every cycle against a behavioural model of the controller. A
// seconds-count model of the counter chain supplies zero_all.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_microwave_timer_ctrl;

`ifdef QUICK_START_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif
  localparam int ALARM_TICKS = 3;

  logic clock = 1'b0;
  logic clear = 1'b0;
  microwave_timer_ctrl_if bus();

  microwave_timer_ctrl #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Counter chain stand-in: remaining cook time in seconds.
  int chain_secs = 0;
  assign bus.zero_all = (chain_secs == 0);

  // Controller model.
  string      m_mode = "IDLE";
  logic [3:0] m_digits[$];
  int         m_alarm_left = 0;
  bit         m_cancel = 1'b0;

  function automatic logic [15:0] m_entry();
    logic [15:0] v = 16'h0000;
    foreach (m_digits[i]) v = {v[11:0], m_digits[i]};
    return v;
  endfunction

  function automatic int bcd_secs(input logic [15:0] d);
    return int'(d[15:12]) * 600 + int'(d[11:8]) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit clr, input bit dc, input bit st, input bit sp,
                            input bit kv, input logic [3:0] kval, input bit tk, input bit za);
    m_cancel = 1'b0;
    if (clr) begin
      m_mode = "IDLE";
      m_digits.delete();
      m_alarm_left = 0;
    end else if (m_mode == "IDLE") begin
      if (dc && !sp) begin
        if (st) begin
          if (m_entry() != 16'h0000) m_mode = "LOAD";
          else if (QUICK) begin
            m_digits = '{4'd0, 4'd0, 4'd3, 4'd0};
            m_mode = "LOAD";
          end
        end else if (kv && kval < 4'd10) begin
          m_digits.push_back(kval);
          if (m_digits.size() > 4) void'(m_digits.pop_front());
        end
      end
    end else if (m_mode == "LOAD") begin
      m_mode = "COOKING";
      m_digits.delete();
    end else if (m_mode == "COOKING") begin
      if (!dc || sp) m_mode = "PAUSED";
      else if (QUICK && st && za) begin
        m_digits = '{4'd0, 4'd0, 4'd3, 4'd0};
        m_mode = "LOAD";
      end else if (tk && za) begin
        m_mode = "DONE";
        m_alarm_left = ALARM_TICKS;
      end
    end else if (m_mode == "PAUSED") begin
      if (dc && sp) begin
        m_mode = "IDLE";
        m_cancel = 1'b1;
      end else if (dc && st) m_mode = "COOKING";
    end else begin
      if (!dc || sp || kv) m_mode = "IDLE";
      else if (tk) begin
        m_alarm_left--;
        if (m_alarm_left == 0) m_mode = "IDLE";
      end
    end
  endtask

  // Model and chain advance on each rising edge from pre-edge values.
  initial begin
    bit s_ce, s_ld, s_clr;
    logic [15:0] s_data;
    forever begin
      @(posedge clock);
      s_clr  = clear;
      s_ce   = bus.count_en;
      s_ld   = bus.loadn;
      s_data = bus.data;
      model_step(clear, bus.door_closed, bus.start, bus.stop, bus.key_valid,
                 bus.key_value, bus.tick, bus.zero_all);
      #1;
      if (s_clr) chain_secs = 0;
      else if (!s_ld) chain_secs = bcd_secs(s_data);
      else if (s_ce && chain_secs > 0) chain_secs--;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("data", bus.data, m_cancel ? 16'h0000 : m_entry());
      chk("loadn", 16'(bus.loadn), 16'(!(m_mode == "LOAD" || m_cancel)));
      chk("count_en", 16'(bus.count_en),
          16'((m_mode == "COOKING") && bus.tick && (chain_secs != 0)));
      chk("magnetron_on", 16'(bus.magnetron_on), 16'(m_mode == "COOKING"));
      chk("alarm", 16'(bus.alarm), 16'(m_mode == "DONE"));
      chk("busy", 16'(bus.busy), 16'(m_mode != "IDLE"));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic key(input logic [3:0] v);
    bus.key_valid = 1'b1;
    bus.key_value = v;
    cyc();
    bus.key_valid = 1'b0;
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic tick_cyc();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.key_valid = 1'b0; bus.key_value = 4'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_closed = 1'b1;

    // Reset values.
    clear = 1'b1; cyc(); cyc(); clear = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst busy", 16'(bus.busy), 16'd0);
    chk("rst loadn", 16'(bus.loadn), 16'd1);
    chk("rst data", bus.data, 16'h0000);
    chk("rst magnetron", 16'(bus.magnetron_on), 16'd0);
    chk("rst alarm", 16'(bus.alarm), 16'd0);
    chk("rst count_en", 16'(bus.count_en), 16'd0);

    // Entry 12:30, invalid digit ignored, start.
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    chk("entry 1230", bus.data, 16'h1230);
    key(4'hA);
    chk("digit A ignored", bus.data, 16'h1230);
    press_start();
    chk("load loadn", 16'(bus.loadn), 16'd0);
    chk("load data", bus.data, 16'h1230);
    cyc();
    chk("load one cycle", 16'(bus.loadn), 16'd1);
    chk("cook magnetron", 16'(bus.magnetron_on), 16'd1);
    bus.tick = 1'b1; #1;
    chk("cook count_en", 16'(bus.count_en), 16'd1);
    cyc(); bus.tick = 1'b0;

    // Door opened mid-cook, then resume without reload.
    bus.door_closed = 1'b0; cyc();
    chk("door pause magnetron", 16'(bus.magnetron_on), 16'd0);
    chk("door pause busy", 16'(bus.busy), 16'd1);
    bus.tick = 1'b1; #1;
    chk("paused count_en", 16'(bus.count_en), 16'd0);
    cyc(); bus.tick = 1'b0;
    bus.door_closed = 1'b1; press_start();
    chk("resume loadn", 16'(bus.loadn), 16'd1);
    chk("resume magnetron", 16'(bus.magnetron_on), 16'd1);

    // start+stop together pauses; stop in PAUSED cancels.
    bus.start = 1'b1; bus.stop = 1'b1; cyc(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("start+stop magnetron", 16'(bus.magnetron_on), 16'd0);
    chk("start+stop busy", 16'(bus.busy), 16'd1);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    chk("cancel loadn", 16'(bus.loadn), 16'd0);
    chk("cancel data", bus.data, 16'h0000);
    chk("cancel busy", 16'(bus.busy), 16'd0);
    cyc();
    chk("cancel one cycle", 16'(bus.loadn), 16'd1);

    // start with empty entry.
    press_start();
    chk("empty start data", bus.data, QUICK ? 16'h0030 : 16'h0000);
    chk("empty start loadn", 16'(bus.loadn), 16'(!QUICK));
    cyc();
    chk("empty start busy", 16'(bus.busy), 16'(QUICK));
    clear = 1'b1; cyc(); clear = 1'b0;

    // clear mid-cook.
    key(4'd4); key(4'd5); press_start(); cyc();
    chk("cook 45 magnetron", 16'(bus.magnetron_on), 16'd1);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clr magnetron", 16'(bus.magnetron_on), 16'd0);
    chk("clr busy", 16'(bus.busy), 16'd0);
    chk("clr loadn", 16'(bus.loadn), 16'd1);
    chk("clr data", bus.data, 16'h0000);
    key(4'hA);
    chk("digit A after clr", bus.data, 16'h0000);

    // 00:02 to completion and alarm.
    key(4'd2); press_start(); cyc();
    tick_cyc(); tick_cyc();
    bus.tick = 1'b1; #1;
    chk("zero count_en", 16'(bus.count_en), 16'd0);
    cyc(); bus.tick = 1'b0;
    chk("done alarm", 16'(bus.alarm), 16'd1);
    chk("done magnetron", 16'(bus.magnetron_on), 16'd0);
    tick_cyc(); tick_cyc();
    chk("alarm held", 16'(bus.alarm), 16'd1);
    tick_cyc();
    chk("alarm end", 16'(bus.alarm), 16'd0);
    chk("alarm end busy", 16'(bus.busy), 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bus.tick      = ($urandom % 3 == 0);
      bus.key_valid = ($urandom % 5 == 0);
      bus.key_value = ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'($urandom % 3);
      bus.start     = ($urandom % 10 == 0);
      bus.stop      = ($urandom % 40 == 0);
      if ($urandom % 25 == 0) bus.door_closed = !bus.door_closed;
      clear         = ($urandom % 300 == 0);
      cyc();
    end
    clear = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
